// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared definitions for the square-root operand feeder.
//   NUM_W / NUM_FRAC   : operand format, unsigned Q16.8
//   SEED_W / SEED_FRAC : seed format, unsigned Q8.4
//   state_t            : feeder FSM encoding (IDLE=0, ISSUE=1, WAIT=2)
//   seed_of()          : power-of-two initial guess from the operand's leading one
package sqrt_pkg;

   localparam int unsigned NUM_W     = 24;
   localparam int unsigned NUM_FRAC  = 8;
   localparam int unsigned SEED_W    = 12;
   localparam int unsigned SEED_FRAC = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Leading one at p means value ~ 2^(p-NUM_FRAC); its root ~ 2^((p-NUM_FRAC)/2).
   // Re-aligning to the seed's binary point gives bit (p>>1) for the Q16.8/Q8.4 pair.
   function automatic logic [SEED_W-1:0] seed_of(input logic [NUM_W-1:0] num);
      logic [NUM_W-1:0] t;
      int unsigned      p;
      logic             found;
      p     = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_W; i++) begin
         t = num >> i;
         if (t[0]) begin
            p     = i;
            found = 1'b1;
         end
      end
      if (!found) return '0;
      return SEED_W'(1) << ((p >> 1) + SEED_FRAC - (NUM_FRAC >> 1));
   endfunction

endpackage

// File: rtl/sqrt_operand_feeder_if.sv
// sqrt_operand_feeder_if: producer stream and core handshake of the feeder.
//   in_valid/in_ready/in_num          : operand stream into the feeder
//   core_start/core_num/core_seed     : operand issue to the sqrt core
//   core_done                         : completion pulse from the core
// Modports: master = feeder side, slave = producer/core environment side.
interface sqrt_operand_feeder_if;
   import sqrt_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [NUM_W-1:0]  in_num;
   logic              core_start;
   logic [NUM_W-1:0]  core_num;
   logic [SEED_W-1:0] core_seed;
   logic              core_done;

   modport master (
      input  in_valid, in_num, core_done,
      output in_ready, core_start, core_num, core_seed
   );

   modport slave (
      output in_valid, in_num, core_done,
      input  in_ready, core_start, core_num, core_seed
   );

endinterface

// File: rtl/sqrt_op_fifo.sv
// sqrt_op_fifo: DEPTH x NUM_W synchronous FIFO with registered full/empty flags.
//   clk, rst   : clock, synchronous active-high reset (flushes contents)
//   wr_en      : push request, ignored while full
//   wr_data    : data to push
//   full       : registered full flag
//   rd_en      : pop request, ignored while empty
//   rd_data    : head entry (register-file read)
//   empty      : registered empty flag
module sqrt_op_fifo
   import sqrt_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [NUM_W-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [NUM_W-1:0] rd_data,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL_M1 = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);

   logic [NUM_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10: begin
               count <= count + 1'b1;
               full  <= (count == CNT_FULL_M1);
               empty <= 1'b0;
            end
            2'b01: begin
               count <= count - 1'b1;
               full  <= 1'b0;
               empty <= (count == CNT_ONE);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sqrt_operand_feeder.sv
// sqrt_operand_feeder: buffers Q16.8 operands, computes a power-of-two seed and
// issues one operand at a time to the Babylonian sqrt core, with a completion watchdog.
//   clk, rst     : clock, synchronous active-high reset (aborts op, flushes FIFO)
//   bus          : sqrt_operand_feeder_if.master (in_valid/in_ready/in_num,
//                  core_start/core_num/core_seed/core_done)
//   busy         : operand outstanding at the core
//   err_timeout  : sticky watchdog expiry flag, cleared only by rst
//   zero_skip    : one-cycle pulse when a zero operand is retired without the core
// Build option: ZERO_SKIP_EN retires zero operands in IDLE instead of issuing them;
// when undefined, zeros are issued with seed 0 and zero_skip is tied low.
// Operand/seed widths come from sqrt_pkg.
module sqrt_operand_feeder
   import sqrt_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   sqrt_operand_feeder_if.master bus,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  zero_skip
);

   localparam int unsigned WD_W   = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t           state;
   state_t           state_nxt;
   logic             fifo_full;
   logic             fifo_empty;
   logic [NUM_W-1:0] head;
   logic             issue;
   logic             skip;
   logic             pop;
   logic             wd_expire;
   logic [WD_W-1:0]  wd;

   sqrt_op_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.in_valid),
      .wr_data (bus.in_num),
      .full    (fifo_full),
      .rd_en   (pop),
      .rd_data (head),
      .empty   (fifo_empty)
   );

   assign bus.in_ready = !fifo_full;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
`ifdef ZERO_SKIP_EN
            if (!fifo_empty && head != '0) state_nxt = ISSUE;
`else
            if (!fifo_empty) state_nxt = ISSUE;
`endif
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            // done on the expiry cycle still counts as a normal completion
            if (bus.core_done || wd_expire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      issue     = (state == ISSUE);
      busy      = (state == WAIT);
      wd_expire = (state == WAIT) && (wd == WD_LAST) && !bus.core_done;
`ifdef ZERO_SKIP_EN
      skip      = (state == IDLE) && !fifo_empty && (head == '0);
`else
      skip      = 1'b0;
`endif
      pop       = issue || skip;
   end

   // Registered core interface, watchdog and status
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.core_start <= 1'b0;
         bus.core_num   <= '0;
         bus.core_seed  <= '0;
         wd             <= '0;
         err_timeout    <= 1'b0;
      end else begin
         bus.core_start <= issue;
         if (issue) begin
            bus.core_num  <= head;
            bus.core_seed <= seed_of(head);
         end
         if (busy && !bus.core_done && !wd_expire) wd <= wd + 1'b1;
         else                                      wd <= '0;
         if (wd_expire) err_timeout <= 1'b1;
      end
   end

`ifdef ZERO_SKIP_EN
   always_ff @(posedge clk) begin
      if (rst) zero_skip <= 1'b0;
      else     zero_skip <= skip;
   end
`else
   assign zero_skip = skip;
`endif

endmodule
